pipe_ctrl: RTL
==============

// Module: pipe_ctrl
// PURPOSE
//  Pipeline sequencing controller for the 5-stage MIPS core.
//  - Merges stall requests from IF, ID, EX and MEM into one stall vector for PC, IF_ID, ID_EX, EX_MEM and MEM_WB.
//  - Accepts committed exceptions/ERET from MEM and issues a one-cycle flush with redirect PC.
//  - Keeps a stall watchdog and a saturating stall-cycle counter.
// PARAMETERS
//  EXC_VEC        32'h0000_0020  exception handler entry PC
//  STALL_TIMEOUT  255            consecutive stall cycles before timeout sets
//  CNT_W          32             width of stall_cycles counter
// PORTS
//  clk           in   1      clock, all state on posedge
//  rst           in   1      reset, synchronous, active-high
//  stallreq_if   in   1      instruction fetch not ready
//  stallreq_id   in   1      load-use hazard detected in ID
//  stallreq_ex   in   1      multi-cycle mult/div busy in EX
//  stallreq_mem  in   1      data bus not ready in MEM
//  exc_valid     in   1      exception/ERET committed in MEM this cycle
//  exc_is_eret   in   1      qualifies exc_valid: 1 = ERET, 0 = exception
//  epc_i         in   32     CP0 EPC, return target for ERET
//  stall         out  6      [0]=PC [1]=IF_ID [2]=ID_EX [3]=EX_MEM [4]=MEM_WB [5]=0
//  flush         out  1      clear all pipeline registers this cycle
//  new_pc        out  32     redirect target, valid while flush=1
//  timeout       out  1      sticky: stall held STALL_TIMEOUT cycles in a row
//  stall_cycles  out  CNT_W  saturating count of cycles with stall!=0
// BEHAVIOUR
//  Reset:
//   - all outputs 0.
//   - state=RUN, watchdog=0, latched target=0.
//  Stall vector: combinational, same cycle as the request. Priority is MEM > EX > ID > IF.
//   - mem -> 6'b011111
//   - ex -> 6'b001111
//   - id -> 6'b000111
//   - if -> 6'b000011
//   - none -> 0
//   - Pipeline registers insert a bubble where stall[i]=1 and stall[i+1]=0; this block does not.
//  FSM states RUN / EXC_WAIT / FLUSH:
//   - RUN: exc_valid & !stallreq_mem -> FLUSH. Latch target = exc_is_eret ? epc_i : EXC_VEC.
//   - RUN: exc_valid & stallreq_mem -> EXC_WAIT, same latch.
//   - EXC_WAIT: stall vector still driven by requests; further exc_valid ignored; !stallreq_mem -> FLUSH.
//   - FLUSH: flush=1 and new_pc=target for exactly 1 cycle. stall forced 0. All requests and exc_valid ignored. -> RUN.
//  Latency: exc_valid in cycle N with MEM ready -> flush=1 in N+1, 0 in N+2.
//  flush and new_pc are registered outputs. new_pc holds its last value when flush=0.
//  Watchdog:
//   - Counts consecutive cycles with stall!=0; cleared on any cycle with stall==0.
//   - Saturates at STALL_TIMEOUT; on reaching it, timeout=1 and stays 1 until rst.
//  stall_cycles: +1 per cycle with stall!=0, saturates at all-ones, never wraps; cleared only by rst.
//  Simultaneous events:
//   - exc_valid with any stall request: exception latched and requests served as above.
//   - rst has priority over every event. rst in EXC_WAIT/FLUSH -> RUN, flush=0 next cycle, pending exception dropped.
// STRUCTURE
//  defines.v:
//   - stall encodings (`STALL_MEM/EX/ID/IF/NONE)
//   - FSM state codes
//   - `EXC_VEC default
//  Single module. The saturating counter is a natural sub-module, sat_cnt #(W,MAX), instanced for the watchdog and stall_cycles.
// TESTING
//  1. Priority: stallreq_id=1, stallreq_mem=1 same cycle -> stall=6'b011111; drop mem -> 6'b000111; drop id -> 0.
//  2. Exception, MEM ready:
//     - exc_valid=1, exc_is_eret=0 at N -> flush=1, new_pc=32'h20 at N+1 only; stall=0 at N+1.
//  3. ERET delayed by MEM:
//     - exc_valid=1, eret=1, epc_i=32'h0000_1234, stallreq_mem=1 for 3 cycles -> stall=6'b011111 during wait.
//     - flush=1, new_pc=32'h1234 on the cycle after mem drops.
//  4. Second exc_valid in EXC_WAIT and FLUSH -> ignored; exactly one flush pulse; target from the first event.
//  5. Watchdog: STALL_TIMEOUT=4, stallreq_ex held 4 cycles -> timeout=1 and stays 1 after release.
//     - Same with 3 cycles, 1 idle, 3 cycles -> timeout stays 0.
//  6. Reset: rst during EXC_WAIT -> next cycle flush=0, stall follows requests, timeout=0, stall_cycles=0.
//     - Counter: CNT_W=3, 9 stall cycles -> stall_cycles=7.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and encodings for the 5-stage pipeline sequencing controller.
package pipe_ctrl_pkg;

    localparam int unsigned STALL_W = 6;
    localparam int unsigned ADDR_W  = 32;

    localparam logic [STALL_W-1:0] STALL_MEM  = 6'b011111;
    localparam logic [STALL_W-1:0] STALL_EX   = 6'b001111;
    localparam logic [STALL_W-1:0] STALL_ID   = 6'b000111;
    localparam logic [STALL_W-1:0] STALL_IF   = 6'b000011;
    localparam logic [STALL_W-1:0] STALL_NONE = 6'b000000;

    localparam logic [ADDR_W-1:0] EXC_VEC_DEFAULT = 32'h0000_0020;

    typedef enum logic [1:0] {
        S_RUN      = 2'd0,
        S_EXC_WAIT = 2'd1,
        S_FLUSH    = 2'd2
    } state_t;

    // Later stages win: a stalled MEM freezes everything upstream of it.
    function automatic logic [STALL_W-1:0] stall_encode(
        input logic req_if,
        input logic req_id,
        input logic req_ex,
        input logic req_mem
    );
        if (req_mem)     return STALL_MEM;
        else if (req_ex) return STALL_EX;
        else if (req_id) return STALL_ID;
        else if (req_if) return STALL_IF;
        return STALL_NONE;
    endfunction

endpackage

// File: rtl/pipe_ctrl_sat_cnt.sv
// Saturating up-counter with synchronous clear; holds at MAX instead of wrapping.
module pipe_ctrl_sat_cnt #(
    parameter int unsigned    W   = 8,
    parameter logic [W-1:0]   MAX = '1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (inc && (count != MAX)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: merges stall requests, sequences exception/ERET
// flushes with a redirect PC, and tracks stall watchdog and stall-cycle statistics.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter logic [ADDR_W-1:0] EXC_VEC       = EXC_VEC_DEFAULT,
    parameter int unsigned       STALL_TIMEOUT = 255,
    parameter int unsigned       CNT_W         = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stallreq_if,
    input  logic                stallreq_id,
    input  logic                stallreq_ex,
    input  logic                stallreq_mem,
    input  logic                exc_valid,
    input  logic                exc_is_eret,
    input  logic [ADDR_W-1:0]   epc_i,
    output logic [STALL_W-1:0]  stall,
    output logic                flush,
    output logic [ADDR_W-1:0]   new_pc,
    output logic                timeout,
    output logic [CNT_W-1:0]    stall_cycles
);

    localparam int unsigned     WD_W   = $clog2(STALL_TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(STALL_TIMEOUT);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   target_q, target_d;
    logic                flush_d;
    logic [ADDR_W-1:0]   new_pc_d;
    logic                stall_any;
    logic [WD_W-1:0]     wd_cnt;

    // State and latched redirect target
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_RUN;
            target_q <= '0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
        end
    end

    // Next state; the target is captured only when leaving RUN
    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        case (state_q)
            S_RUN: begin
                if (exc_valid) begin
                    target_d = exc_is_eret ? epc_i : EXC_VEC;
                    state_d  = stallreq_mem ? S_EXC_WAIT : S_FLUSH;
                end
            end
            S_EXC_WAIT: begin
                if (!stallreq_mem) state_d = S_FLUSH;
            end
            S_FLUSH:  state_d = S_RUN;
            default:  state_d = S_RUN;
        endcase
    end

    // Outputs: stall is same-cycle; flush/new_pc are staged for the next cycle
    always_comb begin
        stall    = STALL_NONE;
        flush_d  = 1'b0;
        new_pc_d = new_pc;
        if (!rst && (state_q != S_FLUSH)) begin
            stall = stall_encode(stallreq_if, stallreq_id, stallreq_ex, stallreq_mem);
        end
        if (state_d == S_FLUSH) begin
            flush_d  = 1'b1;
            new_pc_d = target_d;
        end
    end

    assign stall_any = |stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            flush   <= 1'b0;
            new_pc  <= '0;
            timeout <= 1'b0;
        end else begin
            flush   <= flush_d;
            new_pc  <= new_pc_d;
            timeout <= timeout | (stall_any && (wd_cnt == WD_MAX - WD_W'(1)));
        end
    end

    pipe_ctrl_sat_cnt #(
        .W   (WD_W),
        .MAX (WD_MAX)
    ) u_watchdog (
        .clk   (clk),
        .rst   (rst),
        .clr   (!stall_any),
        .inc   (stall_any),
        .count (wd_cnt)
    );

    pipe_ctrl_sat_cnt #(
        .W   (CNT_W),
        .MAX ({CNT_W{1'b1}})
    ) u_stall_cycles (
        .clk   (clk),
        .rst   (rst),
        .clr   (1'b0),
        .inc   (stall_any),
        .count (stall_cycles)
    );

endmodule
